// File: rtl/victim_writeback_buffer.sv
// Victim writeback buffer: small FIFO of evicted blocks draining to memory,
// with a registered tag lookup so in-flight victims remain readable.
module victim_writeback_buffer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 50,
    parameter int BLOCK_W = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [BLOCK_W-1:0]         in_block,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [BLOCK_W-1:0]         out_block,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       out_ready,
    input  logic                       lookup_en,
    input  logic [TAG_W-1:0]           lookup_tag,
    output logic                       lookup_hit,
    output logic [BLOCK_W-1:0]         lookup_block,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [DEPTH-1:0]   vld;
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [BLOCK_W-1:0] blk_mem [DEPTH];

    logic               push;
    logic               pop;
    logic               match;
    logic [BLOCK_W-1:0] match_blk;
    logic [PTR_W-1:0]   idx;

    assign full      = (occ == CNT_W'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = occ;
    assign out_block = blk_mem[rd_ptr];
    assign out_tag   = tag_mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Walk oldest to newest so the entry just behind wr_ptr overrides older matches.
    always_comb begin
        match     = 1'b0;
        match_blk = '0;
        idx       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - PTR_W'(1) - PTR_W'(k);
            if (vld[idx] && (tag_mem[idx] == lookup_tag)) begin
                match     = 1'b1;
                match_blk = blk_mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Payload storage is not reset; validity is tracked by vld.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            tag_mem[wr_ptr] <= in_tag;
            blk_mem[wr_ptr] <= in_block;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lookup_hit   <= 1'b0;
            lookup_block <= '0;
        end else begin
            lookup_hit <= lookup_en && match;
            if (lookup_en && match) begin
                lookup_block <= match_blk;
            end
        end
    end

endmodule

// File: doc/victim_writeback_buffer.md
# victim_writeback_buffer

Sits directly downstream of the victim cache. It captures each block evicted from the victim cache, together with its 50-bit ptag+vindex, into a small FIFO. It drains those blocks to the next memory level over a valid/ready handshake. While an evicted block waits in the FIFO, a registered lookup port returns it on demand, so data in flight between the victim cache and memory is never lost to a read.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- TAG_W, 50, width of the ptag+vindex tag stored with each block
- BLOCK_W, 512, block width in bits
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_valid  input  1  evicted block presented
- in_block  input  BLOCK_W  evicted block data
- in_tag  input  TAG_W  ptag+vindex of the evicted block
- in_ready  output  1  buffer can accept; equals !full
- out_valid  output  1  oldest entry is available to memory
- out_block  output  BLOCK_W  data of the oldest entry
- out_tag  output  TAG_W  tag of the oldest entry
- out_ready  input  1  memory accepts the oldest entry
- lookup_en  input  1  search request
- lookup_tag  input  TAG_W  tag to search for
- lookup_hit  output  1  registered search result
- lookup_block  output  BLOCK_W  registered data of the matching entry
- count  output  $clog2(DEPTH)+1  number of occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: DEPTH entries, each holding {valid, tag, block}. The buffer keeps a write pointer, a read pointer (both $clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
- Push: occurs when in_valid && in_ready.
  - The entry at the write pointer takes in_tag and in_block, and its valid bit is set.
  - The write pointer increments.
- Pop: occurs when out_valid && out_ready.
  - The valid bit of the entry at the read pointer is cleared.
  - The read pointer increments.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Push and pop in the same cycle (possible only when not full) both take effect.
- When full, in_ready = 0. A push is refused even if a pop happens in that cycle; there is no full-bypass.
- When empty, there is no fall-through: a block pushed in cycle N appears on out_* in cycle N+1.
- out_valid = !empty. out_block and out_tag read the entry at the read pointer combinationally. Their values are don't-care while out_valid = 0.
- Once out_valid = 1, out_block and out_tag stay stable until a pop occurs.
- Lookup (only when lookup_en = 1):
  - The search compares lookup_tag against every entry with valid = 1.
  - It uses state as it was before this edge: an entry pushed in the same cycle is not seen, and an entry popped in the same cycle is still seen.
  - If several entries match, the newest wins (closest behind the write pointer).
  - lookup_hit and lookup_block are registered.
  - When lookup_en = 0, lookup_hit is 0 on the next edge and lookup_block holds its previous value.
- Reset (reset = 0 at a rising edge):
  - Pointers and count become 0 and all valid bits clear.
  - lookup_hit becomes 0 and lookup_block becomes 0.
  - A push or pop presented in the same cycle is ignored.
  - Stored block and tag data need not be cleared.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, full = 0, empty = 1, lookup_hit = 0, lookup_block = 0. out_block and out_tag are don't-care.
- Push-to-out_valid latency is 1 cycle. Pop takes effect at the edge and the next entry is visible in the following cycle.
- Lookup latency is 1 cycle: a request sampled at edge N produces its result during cycle N+1.
- in_ready, full, empty and count are functions of registered state only, with no combinational path from in_valid or out_ready.
- out_valid does not depend on out_ready. The producer may not withdraw a presented block before in_ready; the consumer may deassert out_ready freely.

## Test plan
- Reset then idle:
  - Hold reset = 0 for 2 cycles, then release → in_ready = 1, out_valid = 0, count = 0, empty = 1, lookup_hit = 0.
- Fill and refuse:
  - Push tags 0xA, 0xB, 0xC, 0xD with out_ready = 0 → count = 4, full = 1, in_ready = 0.
  - Present a fifth push (tag 0xE) → it is refused; count stays 4; a later drain yields 0xA, 0xB, 0xC, 0xD in that order with blocks intact.
- Simultaneous push/pop with wrap-around:
  - Start with 3 entries (count = 3), then push and pop every cycle for 10 cycles → count stays 3.
  - Output order matches input order across pointer wrap, and no entry is duplicated or lost.
- Lookup hit/miss and ordering:
  - Buffer holds tag 0x5 with block 0x111, then tag 0x5 again with block 0x222; lookup 0x5 → next cycle lookup_hit = 1, lookup_block = 0x222.
  - Lookup 0x9 → lookup_hit = 0.
  - Lookup of a tag being pushed in the same cycle → lookup_hit = 0.
- Pop and lookup on the same entry:
  - Pop the only entry (tag 0x7) while looking up 0x7 → lookup_hit = 1 the next cycle.
  - Repeat the lookup one cycle later → lookup_hit = 0, empty = 1.
- Mid-operation reset:
  - With count = 3 and a push, a pop and a lookup all active, assert reset = 0 for 1 cycle → count = 0, out_valid = 0, lookup_hit = 0.
  - A subsequent lookup of any previously stored tag → lookup_hit = 0.
